// File: rtl/inst_select_queue.sv
// Instruction-source selector: picks the lowest-index requesting source, queues the
// tagged instruction in a DEPTH-entry FIFO, and issues the head on a step pulse.
// Optional: define INST_SELECT_BYPASS_EN to let a request go straight to curr_inst when
// the queue is empty and an issue is requested on the same edge.
module inst_select_queue #(
  parameter  int WIDTH   = 16,
  parameter  int NUM_SRC = 2,
  parameter  int DEPTH   = 4,
  localparam int SW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_inst,
  input  logic [NUM_SRC-1:0]       src_pulse,
  input  logic                     issue_pulse,
  input  logic                     halt,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         curr_inst,
  output logic [SW-1:0]            curr_src,
  output logic                     inst_valid,
  output logic [CW-1:0]            q_count,
  output logic                     q_empty,
  output logic                     q_full,
  output logic                     overflow,
  output logic                     collision
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] inst;
    logic [SW-1:0]    src;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  entry_t          win_entry;
  logic            any_req;
  logic            multi_req;
  logic            can_pop;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            ovf_set;

  // Explicit wrap compare so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Priority select: scanning downward leaves the lowest set index as the winner.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    win_entry = '0;
    any_req   = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_pulse[i]) begin
        win_entry.inst = src_inst[i*WIDTH +: WIDTH];
        win_entry.src  = SW'(i);
        any_req        = 1'b1;
      end
    end
  end

  assign multi_req = |(src_pulse & (src_pulse - NUM_SRC'(1)));

  assign q_empty = (count == '0);
  assign q_full  = (count == CW'(DEPTH));
  assign q_count = count;

  assign can_pop = issue_pulse && !halt && !q_empty;

`ifdef INST_SELECT_BYPASS_EN
  assign bypass = q_empty && issue_pulse && !halt && any_req && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign pop     = can_pop && !flush;
  assign push    = any_req && (!q_full || can_pop) && !flush && !bypass;
  assign ovf_set = any_req && q_full && !can_pop && !flush;

  // NOTE: the storage array has no reset; its contents are don't-care until written,
  // and leaving it out of the reset keeps it a plain RAM-style register file.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= win_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      curr_inst  <= '0;
      curr_src   <= '0;
      inst_valid <= 1'b0;
      overflow   <= 1'b0;
      collision  <= 1'b0;
    end else begin
      if (flush) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        inst_valid <= 1'b0;
      end else begin
        if (push) begin
          tail <= wrap_inc(tail);
        end
        if (pop) begin
          head       <= wrap_inc(head);
          curr_inst  <= mem[head].inst;
          curr_src   <= mem[head].src;
          inst_valid <= 1'b1;
        end else if (bypass) begin
          curr_inst  <= win_entry.inst;
          curr_src   <= win_entry.src;
          inst_valid <= 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      // Set wins over a same-cycle clear.
      overflow  <= ovf_set   || (overflow  && !clr_err);
      collision <= multi_req || (collision && !clr_err);
    end
  end

endmodule

// File: tb/tb_inst_select_queue.sv
// Directed bench for inst_select_queue: a queue-based reference model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_inst_select_queue;

  localparam int WIDTH   = 16;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [NUM_SRC*WIDTH-1:0] src_inst = '0;
  logic [NUM_SRC-1:0]       src_pulse = '0;
  logic                     issue_pulse = 1'b0;
  logic                     halt = 1'b0;
  logic                     flush = 1'b0;
  logic                     clr_err = 1'b0;
  logic [WIDTH-1:0]         curr_inst;
  logic [0:0]               curr_src;
  logic                     inst_valid;
  logic [2:0]               q_count;
  logic                     q_empty;
  logic                     q_full;
  logic                     overflow;
  logic                     collision;

  int checks = 0;
  int failures = 0;

  inst_select_queue #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .src_inst(src_inst), .src_pulse(src_pulse),
    .issue_pulse(issue_pulse), .halt(halt), .flush(flush), .clr_err(clr_err),
    .curr_inst(curr_inst), .curr_src(curr_src), .inst_valid(inst_valid),
    .q_count(q_count), .q_empty(q_empty), .q_full(q_full),
    .overflow(overflow), .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending instructions plus the presented one.
  typedef struct {
    logic [WIDTH-1:0] inst;
    int               src;
  } ent_t;

  ent_t             mq[$];
  logic [WIDTH-1:0] m_inst = '0;
  int               m_src = 0;
  bit               m_valid = 0;
  bit               m_ovf = 0;
  bit               m_col = 0;

  always @(posedge clk or posedge reset) begin
    int   win;
    int   nset;
    bit   want_issue;
    bit   new_ovf;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_inst = '0; m_src = 0; m_valid = 0; m_ovf = 0; m_col = 0;
    end else begin
      win = -1; nset = 0; new_ovf = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_pulse[i]) begin
          nset++;
          if (win < 0) win = i;
        end
      end
      want_issue = issue_pulse && !halt;
      if (flush) begin
        mq.delete();
        m_valid = 0;
      end else begin
`ifdef INST_SELECT_BYPASS_EN
        if (mq.size() == 0 && want_issue && win >= 0) begin
          m_inst  = src_inst[win*WIDTH +: WIDTH];
          m_src   = win;
          m_valid = 1;
          win     = -1;
        end
`endif
        if (want_issue && mq.size() > 0) begin
          e = mq.pop_front();
          m_inst  = e.inst;
          m_src   = e.src;
          m_valid = 1;
        end
        if (win >= 0) begin
          if (mq.size() < DEPTH) begin
            e.inst = src_inst[win*WIDTH +: WIDTH];
            e.src  = win;
            mq.push_back(e);
          end else begin
            new_ovf = 1;
          end
        end
      end
      if (clr_err) begin
        m_ovf = 0;
        m_col = 0;
      end
      if (new_ovf) m_ovf = 1;
      if (nset > 1) m_col = 1;
    end
  end

  always @(negedge clk) begin
    check("curr_inst",  32'(curr_inst),  32'(m_inst));
    check("curr_src",   32'(curr_src),   32'(m_src));
    check("inst_valid", 32'(inst_valid), 32'(m_valid));
    check("q_count",    32'(q_count),    32'(mq.size()));
    check("q_empty",    32'(q_empty),    32'(mq.size() == 0));
    check("q_full",     32'(q_full),     32'(mq.size() == DEPTH));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("collision",  32'(collision),  32'(m_col));
  end

  // One clock of stimulus: drive at the falling edge, return at the next falling edge.
  task automatic cyc(input logic [15:0] s0, input logic [15:0] s1, input logic [1:0] pulse,
                     input logic iss, input logic hlt, input logic fl, input logic clr);
    src_inst    = {s1, s0};
    src_pulse   = pulse;
    issue_pulse = iss;
    halt        = hlt;
    flush       = fl;
    clr_err     = clr;
    @(negedge clk);
    src_pulse = '0; issue_pulse = 1'b0; halt = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic push0(input logic [15:0] v);
    cyc(v, 16'h0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic issue();
    cyc(16'h0, 16'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_q_empty", 32'(q_empty), 32'd1);
    check("rst_curr", 32'(curr_inst), 32'h0);

    // Fill three entries, then reset in the middle of a cycle.
    for (int i = 1; i <= 3; i++) push0(16'(i));
    check("pre_rst_count", 32'(q_count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("async_count", 32'(q_count), 32'd0);
    check("async_empty", 32'(q_empty), 32'd1);
    check("async_valid", 32'(inst_valid), 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);

    // Two sources, issued in order.
    cyc(16'h1234, 16'h0000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(16'h0000, 16'h00AB, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    issue();
    check("iss1_inst", 32'(curr_inst), 32'h1234);
    check("iss1_src", 32'(curr_src), 32'd0);
    issue();
    check("iss2_inst", 32'(curr_inst), 32'h00AB);
    check("iss2_src", 32'(curr_src), 32'd1);
    check("iss2_empty", 32'(q_empty), 32'd1);

    // Overflow on the fifth push, FIFO order preserved.
    for (int i = 1; i <= 5; i++) push0(16'h1000 + 16'(i));
    check("ovf_full", 32'(q_full), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      issue();
      check("ovf_order", 32'(curr_inst), 32'h1000 + 32'(i));
    end
    cyc(16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow), 32'd0);

    // Simultaneous push and pop on a full queue, then a halted issue.
    for (int i = 1; i <= 4; i++) push0(16'h2000 + 16'(i));
    cyc(16'h2005, 16'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pp_count", 32'(q_count), 32'd4);
    check("pp_inst", 32'(curr_inst), 32'h2001);
    check("pp_ovf", 32'(overflow), 32'd0);
    cyc(16'h0, 16'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    check("halt_inst", 32'(curr_inst), 32'h2001);
    check("halt_count", 32'(q_count), 32'd4);
    // Enqueue proceeds while halted: pop one, then push during halt.
    issue();
    cyc(16'h2006, 16'h0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    check("halt_push", 32'(q_count), 32'd4);

    // Collision keeps only source 0; flush discards a concurrent request.
    cyc(16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(16'hAAAA, 16'hBBBB, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    check("col_count", 32'(q_count), 32'd1);
    check("col_flag", 32'(collision), 32'd1);
    issue();
    check("col_inst", 32'(curr_inst), 32'hAAAA);
    check("col_valid", 32'(inst_valid), 32'd1);
    cyc(16'h5555, 16'h0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    check("fl_count", 32'(q_count), 32'd0);
    check("fl_valid", 32'(inst_valid), 32'd0);
    check("fl_ovf", 32'(overflow), 32'd0);
    check("fl_inst", 32'(curr_inst), 32'hAAAA);
    cyc(16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_col", 32'(collision), 32'd0);

    // Request and issue together on an empty queue.
    cyc(16'h0F0F, 16'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef INST_SELECT_BYPASS_EN
    check("byp_inst", 32'(curr_inst), 32'h0F0F);
    check("byp_count", 32'(q_count), 32'd0);
    check("byp_valid", 32'(inst_valid), 32'd1);
`else
    check("nobyp_inst", 32'(curr_inst), 32'hAAAA);
    check("nobyp_count", 32'(q_count), 32'd1);
    check("nobyp_valid", 32'(inst_valid), 32'd0);
    issue();
    check("nobyp_late", 32'(curr_inst), 32'h0F0F);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
